secuenciador_melodia: RTL and testbench

//  Melody sequencer driving the frequency-divider tone generator. Plays a

---
 rtl/secuenciador_melodia.sv | 251 +++++++++++++++++++++++++
 tb/tb_secuenciador_melodia.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_melodia.sv
// ---------------------------------------------------------------------------
// secuenciador_melodia
//   Melody sequencer feeding the frequency-divider tone generator. Walks a
//   note table (frequency in Hz, duration in ms), drives the current
//   frequency on freq (0 = silence) and leaves a silent articulation gap
//   after every note. Supports play / stop / pause / loop.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   play      start from entry 0 (only acted on while idle)
//   stop      abort playback, wins over play and pause
//   pause     level; freezes playback and silences the output
//   loop_en   restart at entry 0 at end of melody instead of finishing
//   wr_en     note table write strobe
//   wr_addr   note table write address
//   wr_data   [23:12] freq Hz (0 = rest), [11:0] duration ms (0 = end marker)
//   freq      frequency to the divider, zero-extended from 12 bits
//   note_idx  index of the entry currently playing
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse when the melody ends without looping
// ---------------------------------------------------------------------------
module secuenciador_melodia #(
  parameter int TICK_CYCLES = 50000,
  parameter int ADDR_W      = 6,
  parameter int GAP_MS      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic [31:0]       freq,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [11:0]        GAP_LEN    = 12'(GAP_MS);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Note table storage and read register (not reset)
  logic [23:0]        r_mem [DEPTH];
  logic [23:0]        r_rd_data;

  // Control state
  state_t             r_state;
  logic               r_load_ph;
  logic [ADDR_W-1:0]  r_addr;
  logic [PRESC_W-1:0] r_presc;
  logic [11:0]        r_ms;
  logic [11:0]        r_dur;
  logic [11:0]        r_nfreq;
  logic [ADDR_W-1:0]  r_note_idx;
  logic               r_done;

  // Next-state values
  state_t             w_state_nxt;
  logic               w_load_ph_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic [11:0]        w_ms_nxt;
  logic [11:0]        w_dur_nxt;
  logic [11:0]        w_nfreq_nxt;
  logic [ADDR_W-1:0]  w_idx_nxt;
  logic               w_done_nxt;

  // Where to go once a note (and its gap) has finished
  state_t             w_adv_state;
  logic [ADDR_W-1:0]  w_adv_addr;
  logic               w_adv_done;

  logic [11:0]        w_entry_freq;
  logic [11:0]        w_entry_dur;
  logic               w_tick;
  logic [11:0]        w_ms_inc;

  assign w_entry_freq = r_rd_data[23:12];
  assign w_entry_dur  = r_rd_data[11:0];
  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_ms_inc     = r_ms + 12'd1;

  // Table: write port and registered read of the current address. A write
  // hitting the address being read returns the old word; the playing note is
  // latched into r_nfreq/r_dur, so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[r_addr];
  end

  // Advancing past the last entry is an end of melody; the melody is known to
  // be non-empty here, so loop_en alone decides between restarting and done.
  always_comb begin
    w_adv_state = LOAD;
    w_adv_addr  = r_addr + 1'b1;
    w_adv_done  = 1'b0;
    if (r_addr == ADDR_LAST) begin
      w_adv_addr = '0;
      if (!loop_en) begin
        w_adv_state = IDLE;
        w_adv_done  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_ph_nxt = r_load_ph;
    w_addr_nxt    = r_addr;
    w_presc_nxt   = r_presc;
    w_ms_nxt      = r_ms;
    w_dur_nxt     = r_dur;
    w_nfreq_nxt   = r_nfreq;
    w_idx_nxt     = r_note_idx;
    w_done_nxt    = 1'b0;

    if (stop) begin
      w_state_nxt   = IDLE;
      w_load_ph_nxt = 1'b0;
      w_addr_nxt    = '0;
      w_presc_nxt   = '0;
      w_ms_nxt      = '0;
      w_idx_nxt     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (play) begin
            w_state_nxt   = LOAD;
            w_addr_nxt    = '0;
            w_load_ph_nxt = 1'b0;
          end
        end

        // Phase 0 lets the RAM read complete; phase 1 decodes the entry.
        LOAD: begin
          if (!r_load_ph) begin
            w_load_ph_nxt = 1'b1;
          end else begin
            w_load_ph_nxt = 1'b0;
            if (w_entry_dur != 12'd0) begin
              w_state_nxt = PLAY;
              w_nfreq_nxt = w_entry_freq;
              w_dur_nxt   = w_entry_dur;
              w_idx_nxt   = r_addr;
              w_presc_nxt = '0;
              w_ms_nxt    = '0;
            end else if (loop_en && (r_addr != '0)) begin
              // End marker after at least one note: restart from entry 0.
              w_addr_nxt = '0;
            end else begin
              // End marker, not looping, or an empty melody.
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end

        PLAY: begin
          if (!pause) begin
            if (w_tick) begin
              w_presc_nxt = '0;
              w_ms_nxt    = w_ms_inc;
              if (w_ms_inc == r_dur) begin
                w_ms_nxt = '0;
                if (GAP_MS != 0) begin
                  w_state_nxt = GAP;
                end else begin
                  w_state_nxt   = w_adv_state;
                  w_addr_nxt    = w_adv_addr;
                  w_done_nxt    = w_adv_done;
                  w_load_ph_nxt = 1'b0;
                end
              end
            end else begin
              w_presc_nxt = r_presc + 1'b1;
            end
          end
        end

        GAP: begin
          if (!pause) begin
            if (w_tick) begin
              w_presc_nxt = '0;
              w_ms_nxt    = w_ms_inc;
              if (w_ms_inc == GAP_LEN) begin
                w_ms_nxt      = '0;
                w_state_nxt   = w_adv_state;
                w_addr_nxt    = w_adv_addr;
                w_done_nxt    = w_adv_done;
                w_load_ph_nxt = 1'b0;
              end
            end else begin
              w_presc_nxt = r_presc + 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_load_ph  <= 1'b0;
      r_addr     <= '0;
      r_presc    <= '0;
      r_ms       <= '0;
      r_dur      <= '0;
      r_nfreq    <= '0;
      r_note_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_load_ph  <= w_load_ph_nxt;
      r_addr     <= w_addr_nxt;
      r_presc    <= w_presc_nxt;
      r_ms       <= w_ms_nxt;
      r_dur      <= w_dur_nxt;
      r_nfreq    <= w_nfreq_nxt;
      r_note_idx <= w_idx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Pause silences the output in the same cycle it is asserted.
  assign freq     = ((r_state == PLAY) && !pause) ? {20'd0, r_nfreq} : 32'd0;
  assign note_idx = r_note_idx;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_secuenciador_melodia.sv
module tb_secuenciador_melodia;

  localparam int TICK  = 10;
  localparam int ADDRW = 3;
  localparam int GAPMS = 1;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              play;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic              wr_en;
  logic [ADDRW-1:0]  wr_addr;
  logic [23:0]       wr_data;
  logic [31:0]       freq;
  logic [ADDRW-1:0]  note_idx;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  int tab_f [DEPTH];
  int tab_d [DEPTH];

  typedef struct {
    logic [31:0] f;
    logic        b;
    logic        d;
    logic [2:0]  idx;
    bit          ci;
  } exp_t;

  exp_t sb_q[$];

  secuenciador_melodia #(
    .TICK_CYCLES(TICK),
    .ADDR_W     (ADDRW),
    .GAP_MS     (GAPMS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .play    (play),
    .stop    (stop),
    .pause   (pause),
    .loop_en (loop_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .freq    (freq),
    .note_idx(note_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model: per-cycle expected outputs after the play edge ----
  function automatic void sb_push(int f, bit b, bit d, int idx, bit ci);
    exp_t e;
    e.f   = 32'(f);
    e.b   = b;
    e.d   = d;
    e.idx = 3'(idx);
    e.ci  = ci;
    sb_q.push_back(e);
  endfunction

  function automatic void sb_load();
    sb_push(0, 1'b1, 1'b0, 0, 1'b0);
    sb_push(0, 1'b1, 1'b0, 0, 1'b0);
  endfunction

  function automatic void sb_end();
    sb_push(0, 1'b0, 1'b1, 0, 1'b0);
    sb_push(0, 1'b0, 1'b0, 0, 1'b0);
  endfunction

  task automatic sb_gen(input bit lp, input int cap);
    int a;
    bit fin;
    a   = 0;
    fin = 1'b0;
    sb_q.delete();
    sb_load();
    while (!fin && sb_q.size() < cap) begin
      if (tab_d[a] == 0) begin
        if (lp && a != 0) begin
          a = 0;
          sb_load();
        end else begin
          sb_end();
          fin = 1'b1;
        end
      end else begin
        repeat (tab_d[a] * TICK) sb_push(tab_f[a], 1'b1, 1'b0, a, 1'b1);
        repeat (GAPMS * TICK) sb_push(0, 1'b1, 1'b0, 0, 1'b0);
        if (a == DEPTH - 1) begin
          if (lp) begin
            a = 0;
            sb_load();
          end else begin
            sb_end();
            fin = 1'b1;
          end
        end else begin
          a = a + 1;
          sb_load();
        end
      end
    end
    while (sb_q.size() > cap) void'(sb_q.pop_back());
  endtask

  // ---- stimulus helpers ----
  task automatic write_entry(input int a, input int f, input int d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = {12'(f), 12'(d)};
    @(posedge clk); #1;
    wr_en = 1'b0;
    tab_f[a] = f;
    tab_d[a] = d;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (freq !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset: got freq=%0d busy=%b done=%b idx=%0d, want 0 0 0 0",
               freq, busy, done, note_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    write_entry(0, 440, 2);
    write_entry(1, 0, 1);
    write_entry(2, 880, 1);
    write_entry(3, 0, 0);
    loop_en = 1'b0;
    sb_gen(1'b0, 100000);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d || (e.ci && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL basic[%0d]: got freq=%0d busy=%b done=%b idx=%0d, want freq=%0d busy=%b done=%b idx=%0d",
                 i, freq, busy, done, note_idx, e.f, e.b, e.d, e.idx);
      end
      // Overwrite the entry being played; the note in progress must not change.
      if (i == 5) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = {12'd300, 12'd3};
      end
      if (i == 6) wr_en = 1'b0;
    end
    write_entry(0, 440, 2);
  endtask

  task automatic test_loop();
    loop_en = 1'b1;
    sb_gen(1'b1, 95);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d || (e.ci && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL loop[%0d]: got freq=%0d busy=%b done=%b idx=%0d, want freq=%0d busy=%b done=%b idx=%0d",
                 i, freq, busy, done, note_idx, e.f, e.b, e.d, e.idx);
      end
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    loop_en = 1'b0;
    total++;
    if (freq !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 3'd0) begin
      bad++;
      $display("FAIL loop_stop: got freq=%0d busy=%b done=%b idx=%0d, want 0 0 0 0",
               freq, busy, done, note_idx);
    end
  endtask

  task automatic test_pause();
    int n440;
    exp_t z;
    n440 = 0;
    loop_en = 1'b0;
    sb_gen(1'b0, 100000);
    z.f = 32'd0; z.b = 1'b1; z.d = 1'b0; z.idx = 3'd0; z.ci = 1'b0;
    for (int k = 0; k < 15; k++) sb_q.insert(7, z);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      if (freq == 32'd440) n440++;
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d || (e.ci && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL pause[%0d]: got freq=%0d busy=%b done=%b idx=%0d, want freq=%0d busy=%b done=%b idx=%0d",
                 i, freq, busy, done, note_idx, e.f, e.b, e.d, e.idx);
      end
      if (i == 6)  pause = 1'b1;
      if (i == 21) pause = 1'b0;
    end
    total++;
    if (n440 != 20) begin
      bad++;
      $display("FAIL pause_note_len: got %0d cycles at 440, want 20", n440);
    end
  endtask

  task automatic test_stop();
    int ndone;
    int nbusy;
    loop_en = 1'b0;
    sb_gen(1'b0, 60);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d || (e.ci && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL stop_seq[%0d]: got freq=%0d busy=%b done=%b idx=%0d, want freq=%0d busy=%b done=%b idx=%0d",
                 i, freq, busy, done, note_idx, e.f, e.b, e.d, e.idx);
      end
    end
    total++;
    if (freq !== 32'd880 || note_idx !== 3'd2) begin
      bad++;
      $display("FAIL stop_pre: got freq=%0d idx=%0d, want 880 2", freq, note_idx);
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    total++;
    if (freq !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 3'd0) begin
      bad++;
      $display("FAIL stop_now: got freq=%0d busy=%b done=%b idx=%0d, want 0 0 0 0",
               freq, busy, done, note_idx);
    end
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL stop_no_done: got %0d done pulses, want 0", ndone);
    end
    play = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
    stop = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy !== 1'b0) nbusy++;
      @(posedge clk); #1;
    end
    total++;
    if (nbusy != 0) begin
      bad++;
      $display("FAIL stop_and_play: got busy high in %0d cycles, want 0", nbusy);
    end
  endtask

  task automatic test_boundaries();
    int nlate;
    write_entry(0, 0, 0);
    loop_en = 1'b1;
    sb_gen(1'b1, 1000);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d) begin
        bad++;
        $display("FAIL empty[%0d]: got freq=%0d busy=%b done=%b, want freq=%0d busy=%b done=%b",
                 i, freq, busy, done, e.f, e.b, e.d);
      end
    end
    nlate = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) nlate++;
    end
    total++;
    if (nlate != 0) begin
      bad++;
      $display("FAIL empty_idle: got %0d cycles with done or busy high, want 0", nlate);
    end
    loop_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) write_entry(k, 100 + 50 * k, 1);
    sb_gen(1'b0, 100000);
    pulse_play();
    for (int i = 0; sb_q.size() > 0; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (i > 0) begin @(posedge clk); #1; end
      total++;
      if (freq !== e.f || busy !== e.b || done !== e.d || (e.ci && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL full[%0d]: got freq=%0d busy=%b done=%b idx=%0d, want freq=%0d busy=%b done=%b idx=%0d",
                 i, freq, busy, done, note_idx, e.f, e.b, e.d, e.idx);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    play    = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      tab_f[k] = 0;
      tab_d[k] = 0;
    end
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_stop();
    test_boundaries();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
